ahb2mem_pfifo: RTL and testbench

Parametrised synchronous FIFO for the AHB-to-memory bridge datapath. It generalises the fixed 4-entry bridge FIFO to any power-of-two depth. It adds a fill count, programmable almost-full and almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It sits between the AHB slave front end (writer) and the memory-side sequencer (reader), with a single clock domain.

---
 rtl/ahb2mem_pfifo.sv | 116 +++++++++++
 tb/tb_ahb2mem_pfifo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2mem_pfifo.sv
// ahb2mem_pfifo: parametrised single-clock FIFO between the AHB slave front
// end (writer) and the memory-side sequencer (reader). First-word
// fall-through output, fill count, programmable almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module ahb2mem_pfifo #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_fifo_wr,
   input  logic [DWIDTH-1:0] i_fifo_din,
   input  logic              i_fifo_rd,
   input  logic              i_flush,
   input  logic [AWIDTH:0]   i_afull_thr,
   input  logic [AWIDTH:0]   i_aempty_thr,
   input  logic              i_err_clr,
   output logic [DWIDTH-1:0] o_fifo_dout,
   output logic              o_fifo_full,
   output logic              o_fifo_afull,
   output logic              o_fifo_empty,
   output logic              o_fifo_aempty,
   output logic [AWIDTH:0]   o_fifo_cnt,
   output logic              o_ovf,
   output logic              o_udf
);

   localparam int DEPTH = 2 ** AWIDTH;
   localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

   // Storage array and pointers; the pointer MSB is the wrap bit that
   // distinguishes full from empty when the low bits match.
   logic [DWIDTH-1:0] r_mem [DEPTH];
   logic [AWIDTH:0]   r_wptr;
   logic [AWIDTH:0]   r_rptr;
   logic              r_ovf;
   logic              r_udf;

   logic [AWIDTH:0]   w_cnt;
   logic              w_full;
   logic              w_empty;
   logic              w_wr_ok;
   logic              w_rd_ok;

   // Occupancy and status, all derived from the current (pre-edge) pointers.
   assign w_cnt   = r_wptr - r_rptr;
   assign w_full  = (r_wptr[AWIDTH] != r_rptr[AWIDTH]) &&
                    (r_wptr[AWIDTH-1:0] == r_rptr[AWIDTH-1:0]);
   assign w_empty = (r_wptr == r_rptr);

   // Flush takes priority: any access in a flush cycle is simply dropped.
   assign w_wr_ok = i_fifo_wr & ~w_full  & ~i_flush;
   assign w_rd_ok = i_fifo_rd & ~w_empty & ~i_flush;

   // Threshold compares follow the threshold inputs combinationally. A zero
   // almost-full threshold is always met; one above DEPTH is never met.
   assign o_fifo_afull  = (w_cnt >= i_afull_thr);
   assign o_fifo_aempty = (w_cnt <= i_aempty_thr);

   assign o_fifo_full  = w_full;
   assign o_fifo_empty = w_empty;
   assign o_fifo_cnt   = w_cnt;
   assign o_fifo_dout  = r_mem[r_rptr[AWIDTH-1:0]];
   assign o_ovf        = r_ovf;
   assign o_udf        = r_udf;

   // Storage write on an accepted write only.
   // NOTE: the data array has no reset; the pointers alone define which
   // entries are valid, and leaving it unreset lets it map to plain RAM.
   always_ff @(posedge i_clk) begin
      if (w_wr_ok) begin
         r_mem[r_wptr[AWIDTH-1:0]] <= i_fifo_din;
      end
   end

   // Pointer update: async reset, synchronous flush, then independent advances.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr_ok) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_rd_ok) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
      end
   end

   // Sticky error flags: set on an illegal access outside flush, cleared by
   // i_err_clr, with set winning when both happen in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (i_fifo_wr && w_full && !i_flush) begin
            r_ovf <= 1'b1;
         end else if (i_err_clr) begin
            r_ovf <= 1'b0;
         end
         if (i_fifo_rd && w_empty && !i_flush) begin
            r_udf <= 1'b1;
         end else if (i_err_clr) begin
            r_udf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ahb2mem_pfifo.sv
// tb_ahb2mem_pfifo: directed bench for ahb2mem_pfifo (DWIDTH=32, AWIDTH=2).
// Each issued read pushes its hand-computed expectation into a queue; a
// monitor on the falling edge pops and compares whenever a read is presented.
module tb_ahb2mem_pfifo;

   localparam int DWIDTH = 32;
   localparam int AWIDTH = 2;

   logic              i_clk;
   logic              i_rst_n;
   logic              i_fifo_wr;
   logic [DWIDTH-1:0] i_fifo_din;
   logic              i_fifo_rd;
   logic              i_flush;
   logic [AWIDTH:0]   i_afull_thr;
   logic [AWIDTH:0]   i_aempty_thr;
   logic              i_err_clr;
   logic [DWIDTH-1:0] o_fifo_dout;
   logic              o_fifo_full;
   logic              o_fifo_afull;
   logic              o_fifo_empty;
   logic              o_fifo_aempty;
   logic [AWIDTH:0]   o_fifo_cnt;
   logic              o_ovf;
   logic              o_udf;

   typedef struct {
      bit          accept;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   ahb2mem_pfifo #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_fifo_wr    (i_fifo_wr),
      .i_fifo_din   (i_fifo_din),
      .i_fifo_rd    (i_fifo_rd),
      .i_flush      (i_flush),
      .i_afull_thr  (i_afull_thr),
      .i_aempty_thr (i_aempty_thr),
      .i_err_clr    (i_err_clr),
      .o_fifo_dout  (o_fifo_dout),
      .o_fifo_full  (o_fifo_full),
      .o_fifo_afull (o_fifo_afull),
      .o_fifo_empty (o_fifo_empty),
      .o_fifo_aempty(o_fifo_aempty),
      .o_fifo_cnt   (o_fifo_cnt),
      .o_ovf        (o_ovf),
      .o_udf        (o_udf)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every presented read consumes one expectation from the queue.
   always @(negedge i_clk) begin
      if (i_rst_n && i_fifo_rd && !i_flush) begin
         if (exp_q.size() == 0) begin
            check("unexpected_read", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.accept) begin
               check("rd_not_empty", {31'd0, o_fifo_empty}, 32'd0);
               check("rd_data", o_fifo_dout, e.data);
            end else begin
               check("rd_on_empty", {31'd0, o_fifo_empty}, 32'd1);
            end
         end
      end
   end

   // One clock of stimulus; inputs are driven 1 time unit after a rising edge
   // and released 1 unit after the next one, where status is then sampled.
   task automatic step(input bit wr, input logic [31:0] din, input bit rd,
                       input bit flush, input bit clr,
                       input bit rd_accept, input logic [31:0] rd_data);
      if (rd && !flush) begin
         exp_t e;
         e.accept = rd_accept;
         e.data   = rd_data;
         exp_q.push_back(e);
      end
      i_fifo_wr  = wr;
      i_fifo_din = din;
      i_fifo_rd  = rd;
      i_flush    = flush;
      i_err_clr  = clr;
      @(posedge i_clk);
      #1;
      i_fifo_wr = 1'b0;
      i_fifo_rd = 1'b0;
      i_flush   = 1'b0;
      i_err_clr = 1'b0;
   endtask

   task automatic wr(input logic [31:0] d);
      step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic rd(input logic [31:0] d);
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, d);
   endtask

   task automatic chk_cnt(input string name, input int c);
      check(name, {29'd0, o_fifo_cnt}, c);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n      = 1'b0;
      i_fifo_wr    = 1'b0;
      i_fifo_din   = '0;
      i_fifo_rd    = 1'b0;
      i_flush      = 1'b0;
      i_err_clr    = 1'b0;
      i_afull_thr  = 3'd3;
      i_aempty_thr = 3'd1;

      // Reset state.
      repeat (2) @(posedge i_clk);
      #1;
      chk_cnt("rst_cnt", 0);
      check("rst_empty",  {31'd0, o_fifo_empty},  32'd1);
      check("rst_full",   {31'd0, o_fifo_full},   32'd0);
      check("rst_aempty", {31'd0, o_fifo_aempty}, 32'd1);
      check("rst_afull",  {31'd0, o_fifo_afull},  32'd0);
      check("rst_ovf",    {31'd0, o_ovf},         32'd0);
      check("rst_udf",    {31'd0, o_udf},         32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      // Fill: 0x11..0x44, afull from 3, full at 4.
      for (int k = 1; k <= 4; k++) begin
         wr(32'h11 * k);
         chk_cnt("fill_cnt", k);
         check("fill_afull", {31'd0, o_fifo_afull}, (k >= 3) ? 32'd1 : 32'd0);
         check("fill_full",  {31'd0, o_fifo_full},  (k == 4) ? 32'd1 : 32'd0);
      end

      // Drain in order, aempty once cnt<=1.
      for (int k = 1; k <= 4; k++) begin
         rd(32'h11 * k);
         chk_cnt("drain_cnt", 4 - k);
         check("drain_aempty", {31'd0, o_fifo_aempty}, (4 - k <= 1) ? 32'd1 : 32'd0);
         check("drain_empty",  {31'd0, o_fifo_empty},  (k == 4) ? 32'd1 : 32'd0);
      end

      // Wrap-around: pointers cross the wrap bit, never a false full.
      for (int i = 0; i < 10; i++) begin
         wr(32'hA0 + i);
         chk_cnt("wrap_cnt1", 1);
         check("wrap_full", {31'd0, o_fifo_full}, 32'd0);
         rd(32'hA0 + i);
         chk_cnt("wrap_cnt0", 0);
      end

      // Full plus simultaneous rd/wr: head pops, new write dropped, ovf set.
      for (int k = 1; k <= 4; k++) wr(32'h50 + k);
      check("bnd_full", {31'd0, o_fifo_full}, 32'd1);
      step(1'b1, 32'h99, 1'b1, 1'b0, 1'b0, 1'b1, 32'h51);
      chk_cnt("bnd_full_cnt", 3);
      check("bnd_ovf", {31'd0, o_ovf}, 32'd1);
      check("bnd_udf_quiet", {31'd0, o_udf}, 32'd0);
      rd(32'h52);
      rd(32'h53);
      rd(32'h54);
      check("bnd_drained", {31'd0, o_fifo_empty}, 32'd1);

      // Empty plus simultaneous rd/wr: write stored, read rejected, udf set.
      step(1'b1, 32'h77, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      chk_cnt("bnd_empty_cnt", 1);
      check("bnd_udf", {31'd0, o_udf}, 32'd1);
      check("bnd_ovf_held", {31'd0, o_ovf}, 32'd1);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      check("clr_ovf", {31'd0, o_ovf}, 32'd0);
      check("clr_udf", {31'd0, o_udf}, 32'd0);
      chk_cnt("clr_cnt", 1);
      rd(32'h77);
      // Set wins over clear in the same cycle.
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      check("set_wins_udf", {31'd0, o_udf}, 32'd1);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      check("clr2_udf", {31'd0, o_udf}, 32'd0);

      // Streaming at cnt=2 for 20 cycles.
      wr(32'hC0);
      wr(32'hC1);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 32'hC2 + i, 1'b1, 1'b0, 1'b0, 1'b1, 32'hC0 + i);
         chk_cnt("stream_cnt", 2);
      end
      rd(32'hD4);
      rd(32'hD5);
      check("stream_empty", {31'd0, o_fifo_empty}, 32'd1);

      // Flush with concurrent write, then threshold edge cases.
      wr(32'hE0);
      wr(32'hE1);
      wr(32'hE2);
      chk_cnt("preflush_cnt", 3);
      step(1'b1, 32'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      chk_cnt("flush_cnt", 0);
      check("flush_empty", {31'd0, o_fifo_empty}, 32'd1);
      check("flush_ovf", {31'd0, o_ovf}, 32'd0);
      i_afull_thr = 3'd0;
      #1;
      check("thr0_afull", {31'd0, o_fifo_afull}, 32'd1);
      i_afull_thr = 3'd5;
      for (int k = 0; k < 4; k++) wr(32'hF0 + k);
      check("thr5_full", {31'd0, o_fifo_full}, 32'd1);
      check("thr5_afull", {31'd0, o_fifo_afull}, 32'd0);
      i_afull_thr = 3'd3;
      for (int k = 0; k < 4; k++) rd(32'hF0 + k);
      check("thr_drained", {31'd0, o_fifo_empty}, 32'd1);

      // Async reset mid-stream with cnt=3.
      wr(32'h31);
      wr(32'h32);
      wr(32'h33);
      chk_cnt("prerst_cnt", 3);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk_cnt("arst_cnt", 0);
      check("arst_empty",  {31'd0, o_fifo_empty},  32'd1);
      check("arst_full",   {31'd0, o_fifo_full},   32'd0);
      check("arst_aempty", {31'd0, o_fifo_aempty}, 32'd1);
      check("arst_afull",  {31'd0, o_fifo_afull},  32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      wr(32'h5A);
      chk_cnt("post_rst_cnt", 1);
      rd(32'h5A);
      check("post_rst_empty", {31'd0, o_fifo_empty}, 32'd1);

      repeat (2) @(posedge i_clk);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
